dsp_arbiter: RTL and testbench

DSP_ARBITER -- requirements
Module: dsp_arbiter

---
 rtl/dsp_arbiter_pkg.sv | 25 ++
 rtl/dsp_arbiter_addsub.sv | 34 +++
 rtl/dsp_arbiter.sv | 135 +++++++++++++
 tb/tb_dsp_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_arbiter_pkg
// Description : Shared definitions for the two-requester add/sub arbiter:
//               FSM state type and encodings, requester index constants and
//               the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_arbiter_pkg;

   // Default operand/result width; the arbiter only supports 32.
   localparam int DSP_WIDTH = 32;

   // FSM state type and its encodings.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Requester indices, used for the grant and last-served registers.
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage : dsp_arbiter_pkg
`default_nettype wire

// File: rtl/dsp_arbiter_addsub.sv
`default_nettype none
// ============================================================================
// Module      : dsp_arbiter_addsub
// Description : Combinational modulo-2^WIDTH adder/subtractor.
//               Subtraction is A + ~B + 1; carry/borrow out is discarded.
// Ports       : a, b     - operands
//               add_sub  - 0 = a+b, 1 = a-b
//               y        - result
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_arbiter_addsub
   import dsp_arbiter_pkg::*;
#(
   parameter int WIDTH = DSP_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             add_sub,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] cin;

   // Inverting B and injecting a carry-in of one turns the adder into a
   // two's-complement subtractor without a second arithmetic unit.
   always_comb begin
      b_eff = add_sub ? ~b : b;
      cin   = {{(WIDTH-1){1'b0}}, add_sub};
      y     = a + b_eff + cin;
   end

endmodule : dsp_arbiter_addsub
`default_nettype wire

// File: rtl/dsp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dsp_arbiter
// Description : Round-robin arbiter sharing one add/sub unit between two
//               requesters. Each operation walks IDLE -> EXEC -> DONE, so one
//               operation completes every three cycles.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               req0/a0/b0/sub0   - requester 0 request, operands, op select
//               req1/a1/b1/sub1   - requester 1 request, operands, op select
//               done0, done1      - one-cycle completion pulse per requester
//               result            - registered result, valid with doneX
//               busy              - high whenever the FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_arbiter
   import dsp_arbiter_pkg::*;
#(
   parameter int WIDTH = DSP_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             sub0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             sub1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   state_t           state_q,  state_d;
   logic             grant_q,  grant_d;
   logic             last_q,   last_d;
   logic [WIDTH-1:0] opa_q,    opa_d;
   logic [WIDTH-1:0] opb_q,    opb_d;
   logic             opsub_q,  opsub_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0] alu_y;

   // The shared unit only ever sees the latched operands, so requester
   // inputs may change freely once the grant edge has passed.
   dsp_arbiter_addsub #(
      .WIDTH   (WIDTH)
   ) u_addsub (
      .a       (opa_q),
      .b       (opb_q),
      .add_sub (opsub_q),
      .y       (alu_y)
   );

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      opsub_d  = opsub_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               // On a tie, serve whoever was not served last.
               if (req0 && req1) begin
                  grant_d = ~last_q;
               end else if (req0) begin
                  grant_d = REQ0;
               end else begin
                  grant_d = REQ1;
               end
               if (grant_d == REQ0) begin
                  opa_d   = a0;
                  opb_d   = b0;
                  opsub_d = sub0;
               end else begin
                  opa_d   = a1;
                  opb_d   = b1;
                  opsub_d = sub1;
               end
               last_d  = grant_d;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = alu_y;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         grant_q  <= REQ0;
         // Starting with requester 1 as last served lets requester 0 win
         // the first tie after reset.
         last_q   <= REQ1;
         opa_q    <= '0;
         opb_q    <= '0;
         opsub_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         opsub_q  <= opsub_d;
         result_q <= result_d;
      end
   end

   // Outputs decode directly from registered state, so an asynchronous
   // reset clears them immediately and DONE lasts exactly one cycle.
   always_comb begin
      done0  = (state_q == ST_DONE) && (grant_q == REQ0);
      done1  = (state_q == ST_DONE) && (grant_q == REQ1);
      busy   = (state_q != ST_IDLE);
      result = result_q;
   end

endmodule : dsp_arbiter
`default_nettype wire

// File: tb/tb_dsp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_arbiter
// Description : Self-checking bench for dsp_arbiter. A transaction-level
//               reference model schedules each granted operation (grant edge,
//               completion edge, next sampling edge) and compares done0,
//               done1, busy and result after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1, sub0, sub1;
   logic [31:0] a0, b0, a1, b1;
   logic        done0, done1, busy;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   // Reference model state, expressed as an operation schedule.
   int          edge_n;        // number of rising edges seen
   int          free_edge;     // first edge at which a request may be sampled
   int          done_edge;     // edge after which the done pulse is visible
   int          last_srv;      // requester served last (0 or 1)
   int          exp_grantee;
   logic [31:0] exp_pending;   // result of the operation in flight
   logic [31:0] exp_result;    // value the result register should hold
   int          prev_done;     // grantee of the previous completed op

   dsp_arbiter #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .a0     (a0),
      .b0     (b0),
      .sub0   (sub0),
      .req1   (req1),
      .a1     (a1),
      .b1     (b1),
      .sub1   (sub1),
      .done0  (done0),
      .done1  (done1),
      .result (result),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] arith(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      return s ? 32'(a - b) : 32'(a + b);
   endfunction

   // Model reaction to a rising edge, using the inputs held during the cycle.
   task automatic model_edge();
      if (rst) return;
      if (edge_n == done_edge) exp_result = exp_pending;
      if (edge_n >= free_edge && (req0 || req1)) begin
         if (req0 && req1) exp_grantee = 1 - last_srv;
         else              exp_grantee = req0 ? 0 : 1;
         last_srv    = exp_grantee;
         exp_pending = (exp_grantee == 0) ? arith(a0, b0, sub0) : arith(a1, b1, sub1);
         done_edge   = edge_n + 1;
         free_edge   = edge_n + 3;
      end
   endtask

   task automatic check_outputs();
      logic d0, d1, bz;
      d0 = (edge_n == done_edge) && (exp_grantee == 0);
      d1 = (edge_n == done_edge) && (exp_grantee == 1);
      bz = (edge_n == done_edge) || (edge_n == done_edge - 1);
      chk("done0", {31'd0, done0}, {31'd0, d0});
      chk("done1", {31'd0, done1}, {31'd0, d1});
      chk("busy", {31'd0, busy}, {31'd0, bz});
      chk("result", result, exp_result);
      if (done0 || done1) begin
         chk("done_exclusive", {31'd0, done0 & done1}, 32'd0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      edge_n++;
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic model_reset();
      free_edge   = 0;
      done_edge   = -10;
      last_srv    = 1;
      exp_grantee = 0;
      exp_result  = 32'd0;
      exp_pending = 32'd0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
      chk({tag, "_done1"}, {31'd0, done1}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_result"}, result, 32'd0);
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
   endtask

   // Wait for a done pulse of the given requester within a cycle budget.
   task automatic wait_done(input int who, input string tag);
      int n;
      n = 0;
      while (!((who == 0) ? done0 : done1) && n < 8) begin
         cycle();
         n++;
      end
      chk({tag, "_timeout"}, {31'd0, (n >= 8)}, 32'd0);
   endtask

   initial begin
      edge_n    = 0;
      prev_done = -1;
      idle_inputs();
      model_reset();

      // Reset state
      rst = 1'b1;
      #1;
      check_reset_outputs("reset");
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // Single add: 5 + 3 on requester 0
      req0 = 1'b1; a0 = 32'h5; b0 = 32'h3; sub0 = 1'b0;
      cycle();                       // grant edge
      req0 = 1'b0;
      chk("add_busy_exec", {31'd0, busy}, 32'd1);
      cycle();                       // EXEC -> DONE
      chk("add_done0", {31'd0, done0}, 32'd1);
      chk("add_done1_low", {31'd0, done1}, 32'd0);
      chk("add_result", result, 32'h8);
      cycle();

      // Wrap-around subtract and add on requester 1
      req1 = 1'b1; a1 = 32'h0; b1 = 32'h1; sub1 = 1'b1;
      wait_done(1, "sub");
      chk("sub_result", result, 32'hFFFF_FFFF);
      a1 = 32'hFFFF_FFFF; b1 = 32'h1; sub1 = 1'b0;
      cycle();                       // DONE -> IDLE
      wait_done(1, "wrapadd");
      chk("wrapadd_result", result, 32'h0);
      req1 = 1'b0;
      cycle();

      // Operand hold: change a0 after the grant
      req0 = 1'b1; a0 = 32'h10; b0 = 32'h20; sub0 = 1'b0;
      cycle();                       // grant
      a0 = 32'hFF;
      wait_done(0, "hold");
      chk("hold_result", result, 32'h30);
      req0 = 1'b0;
      cycle();

      // Contention from reset: grants must alternate 0,1,0,1,...
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_outputs("rst2");
      req0 = 1'b1; req1 = 1'b1;
      a0 = 32'h100; b0 = 32'h1; a1 = 32'h200; b1 = 32'h2;
      cycle();
      rst = 1'b0;
      prev_done = 1;
      for (int k = 0; k < 24; k++) begin
         cycle();
         if (done0 || done1) begin
            chk("rr_alternate", done0 ? 32'd0 : 32'd1, (prev_done == 0) ? 32'd1 : 32'd0);
            prev_done = done0 ? 0 : 1;
         end
      end
      idle_inputs();
      cycle();
      cycle();
      cycle();

      // Reset mid-operation during EXEC of requester 0
      req0 = 1'b1; a0 = 32'h7; b0 = 32'h9; sub0 = 1'b0;
      cycle();                       // grant, now in EXEC
      chk("midop_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_outputs("midop");
      req0 = 1'b0;
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("midop_no_done0", {31'd0, done0}, 32'd0);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         req0 = ($urandom_range(0, 3) != 0);
         req1 = ($urandom_range(0, 2) != 0);
         sub0 = $urandom_range(0, 1) != 0;
         sub1 = $urandom_range(0, 1) != 0;
         a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         b0 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         a1 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         b1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule : tb_dsp_arbiter
`default_nettype wire
